frame_patch_writer: RTL

Downstream of the bit-flip stage. Takes the flipped word and its frame-buffer address from bit_flip and writes the word back into the readback frame BRAM. It then streams the whole patched frame out of the BRAM on a valid/ready interface toward the ICAP write-back path. It sequences one patch-and-replay per start pulse.

---
 rtl/frame_patch_pkg.sv | 19 +
 rtl/frame_patch_writer_if.sv | 29 ++
 rtl/patch_rd_fifo.sv | 46 ++++
 rtl/frame_patch_writer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/frame_patch_pkg.sv
// Shared types and constants for the frame patch/replay path.
// Sits between bit_flip and the ICAP write-back path.
package frame_patch_pkg;

    localparam int unsigned FRAME_WORDS_DEF = 202;
    localparam int unsigned ADDR_W_DEF      = 13;
    localparam int unsigned DATA_W_DEF      = 32;
    // Header offset shared with bit_flip address generation
    localparam int unsigned HDR_OFFSET      = 105;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FLIP,
        PATCH,
        STREAM,
        FIN
    } state_e;

endpackage

// File: rtl/frame_patch_writer_if.sv
// BRAM port and replay stream bundle between the patch writer and its neighbours.
interface frame_patch_writer_if #(
    parameter int unsigned ADDR_W = frame_patch_pkg::ADDR_W_DEF,
    parameter int unsigned DATA_W = frame_patch_pkg::DATA_W_DEF
);
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output bram_en, bram_we, bram_addr, bram_wdata,
        input  bram_rdata,
        output m_valid, m_data, m_last,
        input  m_ready
    );

    modport slave (
        input  bram_en, bram_we, bram_addr, bram_wdata,
        output bram_rdata,
        input  m_valid, m_data, m_last,
        output m_ready
    );
endinterface

// File: rtl/patch_rd_fifo.sv
// Two-entry read-return FIFO; an arriving word is visible at the head in the
// cycle it returns from the BRAM so an empty FIFO adds no latency.
module patch_rd_fifo #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid_c,
    output logic [W-1:0] head_c,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         rd_idx;
    logic         wr_idx;
    logic         store;
    logic         take;

    assign valid_c = (count != 2'd0) || push;
    assign head_c  = (count != 2'd0) ? mem[rd_idx] : push_data;
    // A returning word popped straight through never occupies an entry
    assign store   = push && !((count == 2'd0) && pop);
    assign take    = pop && (count != 2'd0);

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx <= 1'b0;
            wr_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (store) wr_idx <= ~wr_idx;
            if (take)  rd_idx <= ~rd_idx;
            count <= count + 2'(store) - 2'(take);
        end
    end

endmodule

// File: rtl/frame_patch_writer.sv
// Writes the flipped word into the readback frame BRAM, then replays the whole
// patched frame on a valid/ready stream; one patch-and-replay per start pulse.
module frame_patch_writer
    import frame_patch_pkg::*;
#(
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 flip_done,
    input  logic [DATA_W-1:0]    patch_word,
    input  logic [ADDR_W-1:0]    patch_addr,
    frame_patch_writer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 addr_err
);

    localparam logic [ADDR_W:0]   FRAME_WORDS_X = (ADDR_W+1)'(FRAME_WORDS);
    localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(FRAME_WORDS - 1);

    state_e              state_q;
    state_e              state_d;
    logic [DATA_W-1:0]   word_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic                rd_all_q;
    logic                rvalid_q;
    logic                rlast_q;
    logic                addr_err_q;

    logic                bram_en_c;
    logic                bram_we_c;
    logic [ADDR_W-1:0]   bram_addr_c;
    logic [DATA_W-1:0]   bram_wdata_c;
    logic                patch_ok_c;
    logic                issue_c;
    logic                pop_c;
    logic                fifo_valid_c;
    logic [DATA_W:0]     fifo_head_c;
    logic [1:0]          fifo_count;

    assign patch_ok_c = {1'b0, addr_q} < FRAME_WORDS_X;
    // Reads are throttled so stored plus in-flight words never exceed the FIFO depth
    assign issue_c    = (state_q == STREAM) && !rd_all_q &&
                        ((3'(fifo_count) + 3'(rvalid_q)) < 3'd2);
    assign pop_c      = fifo_valid_c && bus.m_ready;

    patch_rd_fifo #(.W(DATA_W + 1)) u_rd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rvalid_q),
        .push_data ({rlast_q, bus.bram_rdata}),
        .pop       (pop_c),
        .valid_c   (fifo_valid_c),
        .head_c    (fifo_head_c),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and BRAM port drive
    always_comb begin
        state_d      = state_q;
        bram_en_c    = 1'b0;
        bram_we_c    = 1'b0;
        bram_addr_c  = '0;
        bram_wdata_c = '0;
        case (state_q)
            IDLE: begin
                if (start) state_d = WAIT_FLIP;
            end
            WAIT_FLIP: begin
                if (flip_done) state_d = PATCH;
            end
            PATCH: begin
                if (patch_ok_c) begin
                    bram_en_c    = 1'b1;
                    bram_we_c    = 1'b1;
                    bram_addr_c  = addr_q;
                    bram_wdata_c = word_q;
                end
                state_d = STREAM;
            end
            STREAM: begin
                if (issue_c) begin
                    bram_en_c   = 1'b1;
                    bram_addr_c = rd_ptr_q;
                end
                if (pop_c && fifo_head_c[DATA_W]) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q     <= '0;
            addr_q     <= '0;
            rd_ptr_q   <= '0;
            rd_all_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            rvalid_q <= issue_c;
            rlast_q  <= issue_c && (rd_ptr_q == LAST_ADDR);
            if (state_q == IDLE && start) begin
                addr_err_q <= 1'b0;
            end
            if (state_q == WAIT_FLIP && flip_done) begin
                word_q <= patch_word;
                addr_q <= patch_addr;
            end
            if (state_q == PATCH) begin
                rd_ptr_q <= '0;
                rd_all_q <= 1'b0;
                if (!patch_ok_c) addr_err_q <= 1'b1;
            end
            if (issue_c) begin
                if (rd_ptr_q == LAST_ADDR) begin
                    rd_all_q <= 1'b1;
                end else begin
                    rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                end
            end
        end
    end

    assign bus.bram_en    = bram_en_c;
    assign bus.bram_we    = bram_we_c;
    assign bus.bram_addr  = bram_addr_c;
    assign bus.bram_wdata = bram_wdata_c;
    assign bus.m_valid    = fifo_valid_c;
    assign bus.m_data     = fifo_head_c[DATA_W-1:0];
    assign bus.m_last     = fifo_head_c[DATA_W];

    assign busy     = (state_q == WAIT_FLIP) || (state_q == PATCH) || (state_q == STREAM);
    assign done     = (state_q == FIN);
    assign addr_err = addr_err_q;

endmodule
